// File: rtl/ecg_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : ecg_argmax_classifier
//  Description : Sequential arg-max over the ReLU outputs of the ECG MLP output
//                layer. Captures the whole node vector in one cycle, scans one
//                element per cycle and reports the winning class index, its
//                activation and a tie flag (lowest index wins a tie).
//  Revision    : 1.0 - initial release
// ============================================================================
module ecg_argmax_classifier #(
  parameter int N_NODES = 30,
  parameter int DW      = 32,
  parameter int IDX_W   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N_NODES*DW-1:0]   nodes_in,
  output logic                    busy,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        class_idx,
  output logic [DW-1:0]           class_val,
  output logic                    tie
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [IDX_W-1:0] c_FIRST_PTR = IDX_W'(1);
  localparam logic [IDX_W-1:0] c_LAST_PTR  = IDX_W'(N_NODES - 1);

  logic [1:0]       state_q, state_d;

  logic [DW-1:0]    w_nodes [N_NODES];
  logic [DW-1:0]    vec_q   [N_NODES];
  logic [DW-1:0]    vec_d   [N_NODES];

  logic [DW-1:0]    best_val_q, best_val_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             tie_q, tie_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] class_idx_q, class_idx_d;
  logic [DW-1:0]    class_val_q, class_val_d;
  logic             class_tie_q, class_tie_d;

  logic             w_accept;
  logic             w_last;
  logic [DW-1:0]    w_elem;

  // Unflatten the incoming vector so node k is addressable as w_nodes[k].
  for (genvar k = 0; k < N_NODES; k++) begin : g_unpack
    assign w_nodes[k] = nodes_in[k*DW +: DW];
  end

  // A new vector is only taken when no scan is running (IDLE, or the DONE
  // cycle so that vectors can be streamed back to back).
  assign w_accept = in_valid && ((state_q == c_IDLE) || (state_q == c_DONE));
  assign w_last   = (ptr_q == c_LAST_PTR);
  assign w_elem   = vec_q[ptr_q];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (in_valid) state_d = c_SCAN;
      c_SCAN:  if (w_last)   state_d = c_DONE;
      c_DONE:  state_d = in_valid ? c_SCAN : c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM outputs: busy tracks the scan, out_valid marks the single DONE cycle.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      c_SCAN:  busy      = 1'b1;
      c_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture / compare datapath. The result registers are loaded on the edge
  // that enters DONE, so they are already valid while out_valid is high and
  // then hold until the next result.
  always_comb begin
    vec_d       = vec_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    tie_d       = tie_q;
    ptr_d       = ptr_q;
    class_idx_d = class_idx_q;
    class_val_d = class_val_q;
    class_tie_d = class_tie_q;

    if (w_accept) begin
      vec_d      = w_nodes;
      best_val_d = w_nodes[0];
      best_idx_d = '0;
      tie_d      = 1'b0;
      ptr_d      = c_FIRST_PTR;
    end else if (state_q == c_SCAN) begin
      // Unsigned compare: ReLU outputs never set the top bit.
      if (w_elem > best_val_q) begin
        best_val_d = w_elem;
        best_idx_d = ptr_q;
        tie_d      = 1'b0;
      end else if (w_elem == best_val_q) begin
        tie_d      = 1'b1;
      end

      if (w_last) begin
        ptr_d       = '0;
        class_idx_d = best_idx_d;
        class_val_d = best_val_d;
        class_tie_d = tie_d;
      end else begin
        ptr_d       = ptr_q + c_FIRST_PTR;
      end
    end
  end

  // Datapath registers; reset aborts any scan and clears the results.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_NODES; k++) begin
        vec_q[k] <= '0;
      end
      best_val_q  <= '0;
      best_idx_q  <= '0;
      tie_q       <= 1'b0;
      ptr_q       <= '0;
      class_idx_q <= '0;
      class_val_q <= '0;
      class_tie_q <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      tie_q       <= tie_d;
      ptr_q       <= ptr_d;
      class_idx_q <= class_idx_d;
      class_val_q <= class_val_d;
      class_tie_q <= class_tie_d;
    end
  end

  assign class_idx = class_idx_q;
  assign class_val = class_val_q;
  assign tie       = class_tie_q;

endmodule
`default_nettype wire

// File: tb/tb_ecg_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecg_argmax_classifier
//  Description : Self-checking bench for ecg_argmax_classifier: directed
//                corner vectors plus randomized vectors against an arg-max
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecg_argmax_classifier;

  localparam int N_NODES = 30;
  localparam int DW      = 32;
  localparam int IDX_W   = 5;
  localparam int NW      = N_NODES * DW;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [NW-1:0]    nodes_in;
  logic             busy;
  logic             out_valid;
  logic [IDX_W-1:0] class_idx;
  logic [DW-1:0]    class_val;
  logic             tie;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NW-1:0] inj_vec;

  ecg_argmax_classifier #(
    .N_NODES (N_NODES),
    .DW      (DW),
    .IDX_W   (IDX_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .nodes_in  (nodes_in),
    .busy      (busy),
    .out_valid (out_valid),
    .class_idx (class_idx),
    .class_val (class_val),
    .tie       (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: maximum value, first index holding it, tie if it occurs twice+.
  function automatic void ref_argmax(input logic [NW-1:0] v, output int idx,
                                     output logic [DW-1:0] mx, output bit t);
    logic [DW-1:0] a [$];
    int hits;
    for (int k = 0; k < N_NODES; k++) a.push_back(v[k*DW +: DW]);
    mx = '0;
    foreach (a[k]) if (a[k] > mx) mx = a[k];
    idx  = -1;
    hits = 0;
    foreach (a[k]) begin
      if (a[k] == mx) begin
        hits++;
        if (idx < 0) idx = k;
      end
    end
    t = (hits > 1);
  endfunction

  function automatic logic [NW-1:0] fill_all(input logic [DW-1:0] x);
    logic [NW-1:0] r;
    for (int k = 0; k < N_NODES; k++) r[k*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_vec(input int unsigned maxv);
    logic [NW-1:0] r;
    for (int k = 0; k < N_NODES; k++) begin
      if (maxv == 0) r[k*DW +: DW] = $urandom & 32'h7FFF_FFFF;
      else           r[k*DW +: DW] = DW'($urandom_range(maxv, 0));
    end
    return r;
  endfunction

  // Pulse in_valid from the current negedge, then scramble nodes_in so that a
  // late change would corrupt the result if the DUT did not latch it.
  task automatic send_now(input logic [NW-1:0] v);
    nodes_in = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nodes_in = ~v;
  endtask

  task automatic send_vec(input logic [NW-1:0] v);
    @(negedge clk);
    send_now(v);
  endtask

  // Called at the negedge right after the capture edge. Waits for out_valid,
  // optionally injects a vector mid-scan and checks hold of class_idx.
  task automatic collect(input string tag, input logic [NW-1:0] v, input int inject_at,
                         input int hold_idx, input bit tail);
    int edges, busy_cnt, hold_bad, e_idx;
    bit seen, e_tie;
    logic [DW-1:0] e_val;
    ref_argmax(v, e_idx, e_val, e_tie);
    edges = 0; busy_cnt = 0; hold_bad = 0; seen = 1'b0;
    while (!seen && edges < 200) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (hold_idx >= 0 && int'(class_idx) != hold_idx) hold_bad++;
        if (edges == inject_at) begin
          nodes_in = inj_vec;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        edges++;
      end
    end
    in_valid = 1'b0;
    check({tag, ":out_valid_seen"}, 64'(seen), 64'd1);
    // out_valid is seen N_NODES-1 edges after the capture edge.
    check({tag, ":latency"}, 64'(edges), 64'(N_NODES - 1));
    check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'(N_NODES - 1));
    check({tag, ":class_idx"}, 64'(class_idx), 64'(e_idx));
    check({tag, ":class_val"}, 64'(class_val), 64'(e_val));
    check({tag, ":tie"}, 64'(tie), 64'(e_tie));
    if (hold_idx >= 0) check({tag, ":hold_prev"}, 64'(hold_bad), 64'd0);
    if (tail) begin
      @(negedge clk);
      check({tag, ":pulse_1cyc"}, 64'(out_valid), 64'd0);
      check({tag, ":busy_after"}, 64'(busy), 64'd0);
      check({tag, ":val_holds"}, 64'(class_val), 64'(e_val));
    end
  endtask

  initial begin
    logic [NW-1:0] v, a_vec, b_vec;
    int spurious;

    reset    = 1'b1;
    in_valid = 1'b0;
    nodes_in = '0;
    inj_vec  = '0;
    repeat (3) @(negedge clk);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:out_valid", 64'(out_valid), 64'd0);
    check("reset:class_idx", 64'(class_idx), 64'd0);
    check("reset:class_val", 64'(class_val), 64'd0);
    check("reset:tie", 64'(tie), 64'd0);
    reset = 1'b0;

    // Single clear maximum.
    v = fill_all(32'd10);
    v[7*DW +: DW] = 32'd1000;
    send_vec(v);
    collect("single_max", v, -1, -1, 1'b1);

    // Tie between two indices: lowest wins.
    v = fill_all(32'd0);
    v[3*DW +: DW]  = 32'd500;
    v[20*DW +: DW] = 32'd500;
    send_vec(v);
    collect("tie_3_20", v, -1, -1, 1'b1);

    // Last index is the only nonzero.
    v = fill_all(32'd0);
    v[29*DW +: DW] = 32'd1;
    send_vec(v);
    collect("last_idx", v, -1, -1, 1'b1);

    // All zero.
    v = fill_all(32'd0);
    send_vec(v);
    collect("all_zero", v, -1, -1, 1'b1);

    // Tie cleared by a later strictly larger value.
    v = fill_all(32'd0);
    v[0*DW +: DW] = 32'd50;
    v[1*DW +: DW] = 32'd50;
    v[2*DW +: DW] = 32'd60;
    send_vec(v);
    collect("tie_cleared", v, -1, -1, 1'b1);

    // Full-width unsigned compare.
    v = fill_all(32'd3);
    v[5*DW +: DW] = 32'h7FFF_FFFF;
    v[6*DW +: DW] = 32'h7FFF_FFFE;
    send_vec(v);
    collect("large_vals", v, -1, -1, 1'b1);

    // Back to back: B injected mid-scan is dropped; B sent in DONE is taken.
    a_vec = rand_vec(255);
    a_vec[4*DW +: DW] = 32'h1000;
    b_vec = rand_vec(255);
    b_vec[9*DW +: DW] = 32'h2000;
    inj_vec = b_vec;
    send_vec(a_vec);
    collect("b2b_a", a_vec, 10, -1, 1'b0);
    send_now(b_vec);
    collect("b2b_b", b_vec, -1, 4, 1'b1);

    // Reset in the middle of a scan.
    send_vec(a_vec);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid:busy", 64'(busy), 64'd0);
    check("rst_mid:out_valid", 64'(out_valid), 64'd0);
    check("rst_mid:class_idx", 64'(class_idx), 64'd0);
    check("rst_mid:class_val", 64'(class_val), 64'd0);
    check("rst_mid:tie", 64'(tie), 64'd0);
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) spurious++;
    end
    check("rst_mid:no_result", 64'(spurious), 64'd0);
    v = fill_all(32'd7);
    v[17*DW +: DW] = 32'd77;
    send_vec(v);
    collect("after_rst", v, -1, -1, 1'b1);

    // Reset coincident with in_valid: the vector must not be captured.
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    nodes_in = a_vec;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) spurious++;
    end
    check("rst_with_valid:no_capture", 64'(spurious), 64'd0);

    // Randomized vectors, some with dropped mid-scan pulses.
    for (int it = 0; it < 24; it++) begin
      int mode, inj, dup_a, dup_b;
      mode = $urandom_range(2, 0);
      if (mode == 0) v = rand_vec(0);
      else if (mode == 1) v = rand_vec(3);
      else begin
        v = rand_vec(1000);
        dup_a = $urandom_range(N_NODES - 1, 0);
        dup_b = $urandom_range(N_NODES - 1, 0);
        v[dup_a*DW +: DW] = 32'd5000;
        v[dup_b*DW +: DW] = 32'd5000;
      end
      inj = ($urandom_range(1, 0) == 1) ? int'($urandom_range(N_NODES - 3, 0)) : -1;
      inj_vec = rand_vec(0);
      send_vec(v);
      collect($sformatf("rand%0d", it), v, inj, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
